// File: rtl/sc_level_progress.sv
// Goal counter and level tracker feeding the level state machine.
// Counts goal falling edges per level, steps levels, flags the win after MAX_LEVEL.
module sc_level_progress #(
    parameter int LEVEL_DATAWIDTH    = 3,
    parameter int PROGRESS_DATAWIDTH = 5,
    parameter int GOALS_PER_LEVEL    = 5,
    parameter int MAX_LEVEL          = 3
) (
    input  logic                          SC_LEVEL_PROGRESS_CLOCK_50,
    input  logic                          SC_LEVEL_PROGRESS_RESET_InHigh,
    input  logic                          SC_LEVEL_PROGRESS_Start_InLow,
    input  logic                          SC_LEVEL_PROGRESS_Goal_InLow,
    input  logic                          SC_LEVEL_PROGRESS_LifeLost_InLow,
    input  logic                          SC_LEVEL_PROGRESS_GameOver_InLow,
    output logic [LEVEL_DATAWIDTH-1:0]    SC_LEVEL_PROGRESS_CurrentLevel_Out,
    output logic [PROGRESS_DATAWIDTH-1:0] SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    output logic                          SC_LEVEL_PROGRESS_LevelUp_Out,
    output logic                          SC_LEVEL_PROGRESS_GameWon_Out
);

    typedef enum logic [1:0] {
        IDLE,
        PLAYING,
        LEVEL_UP,
        WON
    } state_t;

    localparam logic [LEVEL_DATAWIDTH-1:0]    LevelFirst = LEVEL_DATAWIDTH'(1);
    localparam logic [LEVEL_DATAWIDTH-1:0]    LevelLast  = LEVEL_DATAWIDTH'(MAX_LEVEL);
    localparam logic [PROGRESS_DATAWIDTH-1:0] GoalsFull  = PROGRESS_DATAWIDTH'(GOALS_PER_LEVEL);

    state_t                        state_q, state_d;
    logic [LEVEL_DATAWIDTH-1:0]    level_q, level_d;
    logic [PROGRESS_DATAWIDTH-1:0] count_q, count_d;
    logic                          levelUp_q, levelUp_d;
    logic                          gameWon_q, gameWon_d;
    logic                          goalPrev_q, deathPrev_q;

    logic                          goalEv, deathEv;
    logic [PROGRESS_DATAWIDTH-1:0] countInc;

    // Falling edges only, so a held-low Goal or LifeLost counts once.
    assign goalEv   = goalPrev_q & ~SC_LEVEL_PROGRESS_Goal_InLow;
    assign deathEv  = deathPrev_q & ~SC_LEVEL_PROGRESS_LifeLost_InLow;
    assign countInc = count_q + PROGRESS_DATAWIDTH'(1);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        count_d   = count_q;
        levelUp_d = 1'b0;
        gameWon_d = gameWon_q;
        unique case (state_q)
            IDLE: begin
                level_d   = '0;
                count_d   = '0;
                gameWon_d = 1'b0;
                if (!SC_LEVEL_PROGRESS_Start_InLow) begin
                    state_d = PLAYING;
                    level_d = LevelFirst;
                end
            end
            PLAYING: begin
                gameWon_d = 1'b0;
                if (!SC_LEVEL_PROGRESS_GameOver_InLow) begin
                    state_d = IDLE;
                    level_d = '0;
                    count_d = '0;
                end else if (deathEv) begin
                    count_d = '0;
                end else if (goalEv) begin
                    count_d = countInc;
                    if (countInc == GoalsFull) begin
                        state_d   = LEVEL_UP;
                        levelUp_d = 1'b1;
                    end
                end
            end
            LEVEL_UP: begin
                // The pulse was registered on entry, so an abort here still shows it.
                if (!SC_LEVEL_PROGRESS_GameOver_InLow) begin
                    state_d = IDLE;
                    level_d = '0;
                    count_d = '0;
                end else if (level_q == LevelLast) begin
                    state_d   = WON;
                    gameWon_d = 1'b1;
                end else begin
                    state_d = PLAYING;
                    level_d = level_q + LEVEL_DATAWIDTH'(1);
                    count_d = '0;
                end
            end
            WON: begin
                if (!SC_LEVEL_PROGRESS_GameOver_InLow) begin
                    state_d   = IDLE;
                    level_d   = '0;
                    count_d   = '0;
                    gameWon_d = 1'b0;
                end else if (!SC_LEVEL_PROGRESS_Start_InLow) begin
                    state_d   = PLAYING;
                    level_d   = LevelFirst;
                    count_d   = '0;
                    gameWon_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                level_d   = '0;
                count_d   = '0;
                gameWon_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50 or posedge SC_LEVEL_PROGRESS_RESET_InHigh) begin
        if (SC_LEVEL_PROGRESS_RESET_InHigh) begin
            state_q     <= IDLE;
            level_q     <= '0;
            count_q     <= '0;
            levelUp_q   <= 1'b0;
            gameWon_q   <= 1'b0;
            goalPrev_q  <= 1'b1;
            deathPrev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            count_q     <= count_d;
            levelUp_q   <= levelUp_d;
            gameWon_q   <= gameWon_d;
            goalPrev_q  <= SC_LEVEL_PROGRESS_Goal_InLow;
            deathPrev_q <= SC_LEVEL_PROGRESS_LifeLost_InLow;
        end
    end

    assign SC_LEVEL_PROGRESS_CurrentLevel_Out     = level_q;
    assign SC_LEVEL_PROGRESS_LvlProgressCount_Out = count_q;
    assign SC_LEVEL_PROGRESS_LevelUp_Out          = levelUp_q;
    assign SC_LEVEL_PROGRESS_GameWon_Out          = gameWon_q;

endmodule

// File: tb/tb_sc_level_progress.sv
// Scoreboard bench for sc_level_progress: directed stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_sc_level_progress;

    localparam int Goals = 5;
    localparam int MaxLvl = 3;

    logic       clk;
    logic       rst;
    logic       startN, goalN, lifeN, overN;
    logic [2:0] level;
    logic [4:0] count;
    logic       levelUp, gameWon;

    typedef struct {
        int    cyc;
        int    lvl;
        int    cnt;
        bit    lu;
        bit    won;
        string nm;
    } exp_t;

    exp_t expQ[$];
    exp_t expEntry;
    int   cyc;
    int   checks;
    int   failures;

    sc_level_progress dut (
        .SC_LEVEL_PROGRESS_CLOCK_50            (clk),
        .SC_LEVEL_PROGRESS_RESET_InHigh        (rst),
        .SC_LEVEL_PROGRESS_Start_InLow         (startN),
        .SC_LEVEL_PROGRESS_Goal_InLow          (goalN),
        .SC_LEVEL_PROGRESS_LifeLost_InLow      (lifeN),
        .SC_LEVEL_PROGRESS_GameOver_InLow      (overN),
        .SC_LEVEL_PROGRESS_CurrentLevel_Out    (level),
        .SC_LEVEL_PROGRESS_LvlProgressCount_Out(count),
        .SC_LEVEL_PROGRESS_LevelUp_Out         (levelUp),
        .SC_LEVEL_PROGRESS_GameWon_Out         (gameWon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input int lvl, input int cnt, input bit lu, input bit won);
        checks++;
        if (level !== 3'(lvl) || count !== 5'(cnt) || levelUp !== lu || gameWon !== won) begin
            failures++;
            $display("[TB] FAIL %s: got level=%0d count=%0d levelUp=%0b gameWon=%0b, want level=%0d count=%0d levelUp=%0b gameWon=%0b",
                     nm, level, count, levelUp, gameWon, lvl, cnt, lu, won);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
            expEntry = expQ.pop_front();
            if (expEntry.cyc != cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s: stale expectation for cycle %0d seen at cycle %0d", expEntry.nm, expEntry.cyc, cyc);
            end else begin
                checkOutput(expEntry.nm, expEntry.lvl, expEntry.cnt, expEntry.lu, expEntry.won);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic applyStimulus(input string nm, input logic s, input logic g, input logic l, input logic o,
                                 input int lvl, input int cnt, input bit lu, input bit won);
        exp_t e;
        startN = s;
        goalN  = g;
        lifeN  = l;
        overN  = o;
        e.cyc  = cyc + 1;
        e.lvl  = lvl;
        e.cnt  = cnt;
        e.lu   = lu;
        e.won  = won;
        e.nm   = nm;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Goal edges first..last in level lvl, each held low for hold cycles then released.
    task automatic playLevel(input int lvl, input int first, input int last, input int hold);
        int postL, postC;
        bit postW;
        for (int k = first; k <= last; k++) begin
            applyStimulus("goal_edge", 1, 0, 1, 1, lvl, k, (k == Goals), 0);
            if (k < Goals) begin
                postL = lvl; postC = k; postW = 0;
            end else if (lvl < MaxLvl) begin
                postL = lvl + 1; postC = 0; postW = 0;
            end else begin
                postL = MaxLvl; postC = Goals; postW = 1;
            end
            for (int h = 1; h < hold; h++)
                applyStimulus("goal_held", 1, 0, 1, 1, postL, postC, 0, postW);
            applyStimulus("goal_release", 1, 1, 1, 1, postL, postC, 0, postW);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        cyc = 0; checks = 0; failures = 0;
        rst = 1'b1;
        startN = 1'b1; goalN = 1'b1; lifeN = 1'b1; overN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("idle_goal_ignored", 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("idle_release", 1, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus("start", 0, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus("start_release", 1, 1, 1, 1, 1, 0, 0, 0);
        playLevel(1, 1, 5, 10);

        applyStimulus("over_playing", 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("restart", 0, 1, 1, 1, 1, 0, 0, 0);
        playLevel(1, 1, 3, 1);
        applyStimulus("goal_and_death", 1, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus("release_both", 1, 1, 1, 1, 1, 0, 0, 0);
        playLevel(1, 1, 2, 1);
        applyStimulus("death", 1, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus("death_held", 1, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus("death_release", 1, 1, 1, 1, 1, 0, 0, 0);

        playLevel(1, 1, 5, 1);
        playLevel(2, 1, 5, 1);
        playLevel(3, 1, 5, 1);
        applyStimulus("won_goal_ignored", 1, 0, 1, 1, 3, 5, 0, 1);
        applyStimulus("won_release", 1, 1, 1, 1, 3, 5, 0, 1);
        applyStimulus("won_death_ignored", 1, 1, 0, 1, 3, 5, 0, 1);
        applyStimulus("won_release2", 1, 1, 1, 1, 3, 5, 0, 1);
        applyStimulus("won_start", 0, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus("won_start_release", 1, 1, 1, 1, 1, 0, 0, 0);

        playLevel(1, 1, 5, 1);
        playLevel(2, 1, 4, 1);
        applyStimulus("over_level2", 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("over_release", 1, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus("idle_goal_after_over", 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("idle_release2", 1, 1, 1, 1, 0, 0, 0, 0);

        applyStimulus("start2", 0, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus("start2_release", 1, 1, 1, 1, 1, 0, 0, 0);
        playLevel(1, 1, 5, 1);
        playLevel(2, 1, 2, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_immediate", 0, 0, 0, 0);
        goalN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_held", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("held_goal_idle", 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("start_goal_held", 0, 0, 1, 1, 1, 0, 0, 0);
        applyStimulus("goal_still_low", 1, 0, 1, 1, 1, 0, 0, 0);
        applyStimulus("goal_rise", 1, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus("fresh_goal", 1, 0, 1, 1, 1, 1, 0, 0);
        applyStimulus("fresh_release", 1, 1, 1, 1, 1, 1, 0, 0);

        playLevel(1, 2, 4, 1);
        applyStimulus("goal_into_levelup", 1, 0, 1, 1, 1, 5, 1, 0);
        applyStimulus("goal_low_in_levelup", 1, 0, 1, 1, 2, 0, 0, 0);
        applyStimulus("after_levelup_release", 1, 1, 1, 1, 2, 0, 0, 0);
        applyStimulus("level2_first_goal", 1, 0, 1, 1, 2, 1, 0, 0);
        applyStimulus("level2_release", 1, 1, 1, 1, 2, 1, 0, 0);
        playLevel(2, 2, 4, 1);
        applyStimulus("goal_into_levelup2", 1, 0, 1, 1, 2, 5, 1, 0);
        applyStimulus("over_in_levelup", 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("over_levelup_release", 1, 1, 1, 1, 0, 0, 0, 0);

        applyStimulus("start3", 0, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus("start3_release", 1, 1, 1, 1, 1, 0, 0, 0);
        playLevel(1, 1, 5, 1);
        playLevel(2, 1, 5, 1);
        playLevel(3, 1, 5, 1);
        applyStimulus("won_over_beats_start", 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("final_release", 1, 1, 1, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_level_progress.md
Name: sc_level_progress

Overview:
- Upstream feeder of the level state machine.
- Counts successful frog crossings (goal events), tracks the current level, and produces the CurrentLevel and LvlProgressCount values that the level state machine consumes.
- Issues a one-cycle level-up pulse on level advance and a held game-won flag after the last level.
- All outputs are registered.

Parameters:
- LEVEL_DATAWIDTH, 3, width of current-level output.
- PROGRESS_DATAWIDTH, 5, width of progress count output.
- GOALS_PER_LEVEL, 5, goal events required to finish a level; must satisfy 1 ≤ GOALS_PER_LEVEL ≤ 2^PROGRESS_DATAWIDTH−1.
- MAX_LEVEL, 3, last playable level; must satisfy 1 ≤ MAX_LEVEL ≤ 2^LEVEL_DATAWIDTH−1.

Ports:
- SC_LEVEL_PROGRESS_CLOCK_50, in, 1, system clock; all logic on its rising edge.
- SC_LEVEL_PROGRESS_RESET_InHigh, in, 1, asynchronous active-high reset.
- SC_LEVEL_PROGRESS_Start_InLow, in, 1, start-game request, active low, level-sensitive.
- SC_LEVEL_PROGRESS_Goal_InLow, in, 1, frog at goal row, active low; may be held low for many cycles.
- SC_LEVEL_PROGRESS_LifeLost_InLow, in, 1, frog died, active low; may be held low.
- SC_LEVEL_PROGRESS_GameOver_InLow, in, 1, game aborted by main FSM, active low.
- SC_LEVEL_PROGRESS_CurrentLevel_Out, out, LEVEL_DATAWIDTH, current level; 0 = no game.
- SC_LEVEL_PROGRESS_LvlProgressCount_Out, out, PROGRESS_DATAWIDTH, goals completed in current level.
- SC_LEVEL_PROGRESS_LevelUp_Out, out, 1, one-cycle pulse on level completion.
- SC_LEVEL_PROGRESS_GameWon_Out, out, 1, high while in WON.

Behaviour:
- Reset (asynchronous, any time, including mid-level or mid-LEVEL_UP):
  - state = IDLE, level = 0, count = 0, LevelUp = 0, GameWon = 0.
  - Edge-detect registers for Goal and LifeLost are set to 1 (inactive).
- Input timing: all inputs are synchronous to the clock; no synchronizers.
- Event detection:
  - goal_ev = Goal_prev==1 && Goal_InLow==0. This is a falling edge, so a held-low input counts exactly once.
  - death_ev is derived from LifeLost the same way.
  - Edge registers update every cycle in every state.
- Latency: count/level change on the same clock edge that first samples the input low, so the new value is visible one cycle after the input falls.
- States: IDLE, PLAYING, LEVEL_UP, WON.
- IDLE:
  - Outputs: level 0, count 0.
  - Start_InLow==0 → PLAYING with level = 1, count = 0.
  - Goal and death events are ignored.
- PLAYING:
  - GameOver_InLow==0 → IDLE, level 0, count 0. GameOver has highest priority.
  - Else death_ev → count = 0; level unchanged. Death beats a goal event in the same cycle.
  - Else goal_ev → count = count+1. If count+1 == GOALS_PER_LEVEL → LEVEL_UP.
  - Start is ignored.
- LEVEL_UP (exactly one cycle):
  - LevelUp_Out = 1; count holds GOALS_PER_LEVEL.
  - If level == MAX_LEVEL → WON, GameWon = 1, level and count held.
  - Else level = level+1, count = 0 → PLAYING.
  - Goal edges arriving in this cycle are dropped.
  - GameOver in this cycle → IDLE with no level change; LevelUp still pulses this cycle.
- WON:
  - Outputs: level = MAX_LEVEL, count = GOALS_PER_LEVEL, GameWon = 1.
  - Goal and death events are ignored.
  - Start_InLow==0 → PLAYING, level 1, count 0, GameWon 0.
  - GameOver_InLow==0 → IDLE. GameOver beats Start when both are active in the same cycle.
- Arithmetic: count never exceeds GOALS_PER_LEVEL and never wraps; level never exceeds MAX_LEVEL.
- LevelUp_Out is 0 in every state except LEVEL_UP.

Test Plan:
- Reset, then Start low for 1 cycle → level 1, count 0. Five Goal falling edges, each held low 10 cycles → count 1,2,3,4,5, each change exactly once per edge. Then LevelUp pulses 1 cycle, level 2, count 0.
- Level 1, count 3; Goal and LifeLost fall in the same cycle → count 0, level 1, no LevelUp.
- Complete levels 1–3 (15 goal edges) → three LevelUp pulses. Final state WON with level 3, count 5, GameWon 1. Further goal edges → no change. Start low → level 1, count 0, GameWon 0.
- Level 2, count 4; GameOver low → next cycle level 0, count 0. Subsequent goal edges in IDLE → no change.
- Assert reset asynchronously mid-level (level 2, count 2), between clock edges → outputs 0 immediately, before next clock edge. Goal held low across reset release → no count (edge register reset to 1 requires a fresh falling edge; a low already present counts only if it went high first).
- Goal falls in the LEVEL_UP cycle → edge dropped, new level starts with count 0.
